// File: rtl/mos6502_decode_queue.sv
// Wishbone opcode queue: input FIFO -> one-cycle 6502 decode stage -> output FIFO.
// Define DECODE_STATS_EN to add the decoded/illegal counters at 0x14/0x18.
module mos6502_decode_queue #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Decode word: bits [55:0] one-hot mnemonic (alphabetical ADC..TYA), [65:56] addressing mode.
  localparam logic [3:0] M_IMP = 4'd0, M_ZP = 4'd1, M_ZPI = 4'd2, M_ABS = 4'd3, M_IMM = 4'd4;
  localparam logic [3:0] M_ABSI = 4'd5, M_INDX = 4'd6, M_INDY = 4'd7, M_REL = 4'd8, M_IND = 4'd9;

  localparam logic [5:0] ALU_MN  [8] = '{6'd34, 6'd1, 6'd23, 6'd0, 6'd47, 6'd29, 6'd17, 6'd43};
  localparam logic [3:0] ALU_MD  [8] = '{M_INDX, M_ZP, M_IMM, M_ABS, M_INDY, M_ZPI, M_ABSI, M_ABSI};
  localparam logic [5:0] RMW_MN  [8] = '{6'd2, 6'd39, 6'd32, 6'd40, 6'd48, 6'd30, 6'd20, 6'd24};
  localparam logic [5:0] XFER_MN [4] = '{6'd53, 6'd50, 6'd21, 6'd33};
  localparam logic [5:0] CTL_MN  [8] = '{6'd0, 6'd6, 6'd27, 6'd27, 6'd49, 6'd31, 6'd19, 6'd18};
  localparam logic [5:0] SYS_MN  [4] = '{6'd10, 6'd28, 6'd41, 6'd42};
  localparam logic [5:0] STK_MN  [8] = '{6'd36, 6'd38, 6'd35, 6'd37, 6'd22, 6'd51, 6'd26, 6'd25};
  localparam logic [5:0] BR_MN   [8] = '{6'd9, 6'd7, 6'd11, 6'd12, 6'd3, 6'd4, 6'd8, 6'd5};
  localparam logic [5:0] FLG_MN  [8] = '{6'd13, 6'd44, 6'd15, 6'd46, 6'd55, 6'd16, 6'd14, 6'd45};

  function automatic logic [65:0] decode_op(input logic [7:0] op);
    logic [2:0] a, b;
    logic [1:0] c;
    logic [5:0] mn;
    logic [3:0] md;
    logic       ok;
    decode_op = '0;
    {a, b, c} = op;
    mn = ALU_MN[a];
    md = ALU_MD[b];
    ok = 1'b1;
    case (c)
      2'b01: ok = (op != 8'h89);
      2'b10: begin
        mn = RMW_MN[a];
        case (b)
          3'd0: begin md = M_IMM; ok = (a == 3'd5); end
          3'd2: begin md = M_IMP; if (a[2]) mn = XFER_MN[a[1:0]]; end
          3'd4: ok = 1'b0;
          3'd6: begin md = M_IMP; ok = (a == 3'd4) || (a == 3'd5); mn = a[0] ? 6'd52 : 6'd54; end
          3'd7: ok = (a != 3'd4);
          default: ;
        endcase
      end
      2'b00: begin
        mn = CTL_MN[a];
        case (b)
          3'd0: begin
            if (a[2]) begin
              md = M_IMM;
              ok = (a != 3'd4);
            end else begin
              mn = SYS_MN[a[1:0]];
              md = (a == 3'd1) ? M_ABS : M_IMP;
            end
          end
          3'd1: ok = (a == 3'd1) || a[2];
          3'd2: begin mn = STK_MN[a]; md = M_IMP; end
          3'd3: begin ok = (a != 3'd0); if (a == 3'd3) md = M_IND; end
          3'd4: begin mn = BR_MN[a]; md = M_REL; end
          3'd5: ok = (a == 3'd4) || (a == 3'd5);
          3'd6: begin mn = FLG_MN[a]; md = M_IMP; end
          default: ok = (a == 3'd5);
        endcase
      end
      default: ok = 1'b0;
    endcase
    if (ok) begin
      decode_op[{1'b0, mn}]         = 1'b1;
      decode_op[7'd56 + {3'd0, md}] = 1'b1;
    end
  endfunction

  logic [31:0] off;
  logic [2:0]  ridx;
  logic        req, wr_push, wr_stat, rd_pop;
  assign off     = wbs_adr_i - BASE_ADDR;
  assign ridx    = off[4:2];
  assign req     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & (off <= 32'h1C);
  assign wr_push = req & wbs_we_i & (ridx == 3'd0);
  assign wr_stat = req & wbs_we_i & (ridx == 3'd4);
  assign rd_pop  = req & ~wbs_we_i & (ridx == 3'd3);

  logic [7:0]    imem [DEPTH];
  logic [73:0]   omem [DEPTH];
  logic [AW-1:0] i_wptr, i_rptr, o_wptr, o_rptr;
  logic [CW-1:0] i_cnt, o_cnt;
  logic [AW-1:0] lane_off [4];
  logic [2:0]    n_sel;
  logic [8:0]    i_free;
  logic          push_ok, push_ovf, d_take, d_drain, pop, unf_set, ovf, unf, busy;

  always_comb begin
    n_sel = 3'd0;
    for (int k = 0; k < 4; k++) begin
      lane_off[k] = AW'(n_sel);
      n_sel = n_sel + {2'd0, wbs_sel_i[k]};
    end
  end

  assign i_free   = 9'(DEPTH) - 9'(i_cnt);
  assign push_ok  = wr_push & (9'(n_sel) <= i_free);
  assign push_ovf = wr_push & ~push_ok;
  assign pop      = rd_pop & (o_cnt != '0);
  assign unf_set  = rd_pop & (o_cnt == '0);

  // Stage 0: input-FIFO head and its combinational decode
  logic [7:0]  op_p0;
  logic [65:0] dec_p0;
  assign op_p0  = imem[i_rptr];
  assign dec_p0 = decode_op(op_p0);

  // Stage D: registered {opcode, decode}, drains only when the output FIFO has room
  logic [7:0]  op_p1;
  logic [65:0] dec_p1;
  logic        vld_p1;
  assign d_drain = vld_p1 & (o_cnt != FULL);
  assign d_take  = (i_cnt != '0) & (~vld_p1 | d_drain);
  assign busy    = (i_cnt != '0) | vld_p1;

  always_ff @(posedge wb_clk_i) begin
    if (push_ok)
      for (int k = 0; k < 4; k++)
        if (wbs_sel_i[k]) imem[i_wptr + lane_off[k]] <= wbs_dat_i[8*k +: 8];
    if (d_drain) omem[o_wptr] <= {op_p1, dec_p1};
    if (d_take) begin
      op_p1  <= op_p0;
      dec_p1 <= dec_p0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      i_wptr <= '0;
      i_rptr <= '0;
      i_cnt  <= '0;
      o_wptr <= '0;
      o_rptr <= '0;
      o_cnt  <= '0;
      vld_p1 <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (push_ok) i_wptr <= i_wptr + AW'(n_sel);
      if (d_take) i_rptr <= i_rptr + AW'(1);
      i_cnt <= i_cnt + (push_ok ? CW'(n_sel) : '0) - CW'(d_take);
      if (d_drain) o_wptr <= o_wptr + AW'(1);
      if (pop) o_rptr <= o_rptr + AW'(1);
      o_cnt <= o_cnt + CW'(d_drain) - CW'(pop);
      if (d_take) vld_p1 <= 1'b1;
      else if (d_drain) vld_p1 <= 1'b0;
      if (wr_stat && wbs_dat_i[16]) ovf <= 1'b0;
      else if (push_ovf) ovf <= 1'b1;
      if (wr_stat && wbs_dat_i[17]) unf <= 1'b0;
      else if (unf_set) unf <= 1'b1;
    end
  end

`ifdef DECODE_STATS_EN
  logic [31:0] stat_dec, stat_ill;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      stat_dec <= '0;
      stat_ill <= '0;
    end else begin
      if (req && wbs_we_i && ridx == 3'd5) stat_dec <= '0;
      else if (d_drain) stat_dec <= stat_dec + 32'd1;
      if (req && wbs_we_i && ridx == 3'd6) stat_ill <= '0;
      else if (d_drain && dec_p1 == '0) stat_ill <= stat_ill + 32'd1;
    end
  end
`endif

  logic [73:0] o_head;
  logic [31:0] rdata;
  assign o_head = omem[o_rptr];

  always_comb begin
    rdata = '0;
    case (ridx)
      3'd1: if (o_cnt != '0) rdata = o_head[31:0];
      3'd2: if (o_cnt != '0) rdata = o_head[63:32];
      3'd3: if (o_cnt != '0)
              rdata = {7'd0, 1'b1, 7'd0, (o_head[65:0] == '0), o_head[73:66], 6'd0, o_head[65:64]};
      3'd4: rdata = {13'd0, busy, unf, ovf, 8'(o_cnt), 8'(i_cnt)};
`ifdef DECODE_STATS_EN
      3'd5: rdata = stat_dec;
      3'd6: rdata = stat_ill;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      if (req) wbs_dat_o <= wbs_we_i ? 32'd0 : rdata;
    end
  end

endmodule

// File: tb/tb_mos6502_decode_queue.sv
// Scoreboard bench for mos6502_decode_queue: pushed opcodes queue their expected results,
// RES_* reads pop and compare against a hand-written decode table.
module tb_mos6502_decode_queue;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat_i = '0, adr = '0;
  logic        ack;
  logic [31:0] dat_o;

  int checks = 0, failures = 0;
  int n_dec = 0, n_ill = 0;
  logic [7:0] sb_q[$];
  logic [7:0] op_tab [12] = '{8'hA9, 8'hEA, 8'h6D, 8'h02, 8'h4C, 8'h6C,
                              8'hF0, 8'h8D, 8'hBE, 8'h0A, 8'h91, 8'h89};

  always #5 clk = ~clk;

  mos6502_decode_queue #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o));

  function automatic logic [65:0] ref_dec(input logic [7:0] op);
    ref_dec = '0;
    case (op)
      8'hA9: begin ref_dec[29] = 1'b1; ref_dec[60] = 1'b1; end
      8'hEA: begin ref_dec[33] = 1'b1; ref_dec[56] = 1'b1; end
      8'h6D: begin ref_dec[0]  = 1'b1; ref_dec[59] = 1'b1; end
      8'h4C: begin ref_dec[27] = 1'b1; ref_dec[59] = 1'b1; end
      8'h6C: begin ref_dec[27] = 1'b1; ref_dec[65] = 1'b1; end
      8'hF0: begin ref_dec[5]  = 1'b1; ref_dec[64] = 1'b1; end
      8'h8D: begin ref_dec[47] = 1'b1; ref_dec[59] = 1'b1; end
      8'hBE: begin ref_dec[30] = 1'b1; ref_dec[61] = 1'b1; end
      8'h0A: begin ref_dec[2]  = 1'b1; ref_dec[56] = 1'b1; end
      8'h91: begin ref_dec[47] = 1'b1; ref_dec[63] = 1'b1; end
      default: ;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      input int limit, output logic [31:0] rd, output logic got_ack);
    @(posedge clk); #1;
    adr = a; we = w; dat_i = d; sel = s; stb = 1'b1; cyc = 1'b1;
    got_ack = 1'b0;
    rd = '0;
    for (int i = 0; i < limit && !got_ack; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got_ack = 1'b1;
        rd = dat_o;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    logic        g;
    xfer(BASE + o, 1'b1, d, s, 16, v, g);
    if (!g) chk("ack_timeout_wr", {31'd0, g}, 32'd1);
  endtask

  task automatic rd(input logic [31:0] o, output logic [31:0] v);
    logic g;
    xfer(BASE + o, 1'b0, 32'd0, 4'hF, 16, v, g);
    if (!g) chk("ack_timeout_rd", {31'd0, g}, 32'd1);
  endtask

  task automatic push_ops(input logic [31:0] d, input logic [3:0] s);
    logic [7:0] op;
    wr(32'h00, d, s);
    for (int k = 0; k < 4; k++)
      if (s[k]) begin
        op = d[8*k +: 8];
        sb_q.push_back(op);
        n_dec++;
        if (ref_dec(op) == '0) n_ill++;
      end
  endtask

  task automatic pop_check();
    logic [7:0]  op;
    logic [65:0] e;
    logic [31:0] v;
    op = sb_q.pop_front();
    e  = ref_dec(op);
    rd(32'h04, v); chk($sformatf("res_lo_%02h", op), v, e[31:0]);
    rd(32'h08, v); chk($sformatf("res_mid_%02h", op), v, e[63:32]);
    rd(32'h0C, v);
    chk($sformatf("res_hi_%02h", op), v, {7'd0, 1'b1, 7'd0, (e == '0), op, 6'd0, e[65:64]});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, st;
    logic        g;
    logic [3:0]  s;
    logic [31:0] d;
    int          n;

    idle(3);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    rd(32'h10, v); chk("rst_status", v, 32'd0);

    push_ops(32'h0000_00A9, 4'h1);
    idle(4);
    rd(32'h04, v); chk("lda_lo", v, 32'h2000_0000);
    rd(32'h08, v); chk("lda_mid", v, 32'h1000_0000);
    rd(32'h0C, v); chk("lda_hi", v, 32'h0100_A900);
    void'(sb_q.pop_front());
    rd(32'h10, v); chk("lda_status", v, 32'd0);

    rd(32'h1C, v); chk("reserved_rd", v, 32'd0);
    rd(32'h0C, v); chk("unf_rd", v, 32'd0);
    xfer(BASE + 32'h20, 1'b0, 32'd0, 4'hF, 4, v, g);
    chk("oow_hi_ack", {31'd0, g}, 32'd0);
    xfer(BASE - 32'h4, 1'b1, 32'h0000_00A9, 4'h1, 4, v, g);
    chk("oow_lo_ack", {31'd0, g}, 32'd0);
    rd(32'h10, v); chk("unf_status", v, 32'h0002_0000);
    wr(32'h1C, 32'hFFFF_FFFF, 4'hF);
    wr(32'h10, 32'h0002_0000, 4'hF);
    rd(32'h10, v); chk("unf_clear", v, 32'd0);

    push_ops(32'h6DA9_EAA9, 4'hF);
    idle(6);
    rd(32'h10, v); chk("packed_status", v, 32'h0000_0400);
    for (int i = 0; i < 4; i++) pop_check();

    push_ops(32'h0000_0002, 4'h1);
    idle(4);
    rd(32'h0C, v); chk("ill_hi", v, 32'h0101_0200);
    void'(sb_q.pop_front());
`ifdef DECODE_STATS_EN
    rd(32'h18, v); chk("stat_ill", v, 32'(n_ill));
    rd(32'h14, v); chk("stat_dec", v, 32'(n_dec));
    wr(32'h14, 32'h1234_5678, 4'hF);
    rd(32'h14, v); chk("stat_dec_clr", v, 32'd0);
`else
    rd(32'h14, v); chk("stat_dec_off", v, 32'd0);
    rd(32'h18, v); chk("stat_ill_off", v, 32'd0);
`endif

    push_ops(32'h0A6C_4CF0, 4'hF); idle(4);
    push_ops(32'h918D_BEEA, 4'hF); idle(4);
    push_ops(32'hA96D_0289, 4'hF); idle(4);
    push_ops(32'hEA4C_F0A9, 4'hF); idle(10);
    rd(32'h10, v); chk("full_status", v, 32'h0004_0807);
    wr(32'h00, 32'h0A0A_0A0A, 4'hF);
    rd(32'h10, v); chk("ovf_status", v, 32'h0005_0807);
    wr(32'h10, 32'h0001_0000, 4'hF);
    rd(32'h10, v); chk("ovf_clear", v, 32'h0004_0807);
    push_ops(32'h0000_0091, 4'h1); idle(2);
    rd(32'h10, v); chk("exact_fill", v, 32'h0004_0808);
    wr(32'h00, 32'h0000_00EA, 4'h1);
    rd(32'h10, v); chk("ovf_one", v, 32'h0005_0808);
    wr(32'h10, 32'h0001_0000, 4'hF);
    pop_check();
    rd(32'h10, v); chk("held_refill", v, 32'h0004_0807);
    while (sb_q.size() != 0) pop_check();

    for (int it = 0; it < 16; it++) begin
      rd(32'h10, st);
      s = 4'($urandom_range(1, 15));
      n = $countones(s);
      d = {op_tab[$urandom_range(0, 11)], op_tab[$urandom_range(0, 11)],
           op_tab[$urandom_range(0, 11)], op_tab[$urandom_range(0, 11)]};
      if ((sb_q.size() == 0 || $urandom_range(0, 2) != 0) && (DEPTH - int'(st[7:0])) >= n) begin
        push_ops(d, s);
        idle(12);
      end else if (sb_q.size() != 0) begin
        pop_check();
      end
    end
    for (int i = 0; i < 80 && sb_q.size() != 0; i++) pop_check();
    idle(4);
    rd(32'h10, v); chk("rand_final_status", v, 32'd0);

    push_ops(32'h0000_EAA9, 4'h3);
    idle(6);
    @(posedge clk); #1;
    adr = BASE + 32'h0C; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", {31'd0, ack}, 32'd0);
    chk("arst_dat", dat_o, 32'd0);
    @(posedge clk); #1;
    chk("arst_ack_hold", {31'd0, ack}, 32'd0);
    stb = 1'b0; cyc = 1'b0;
    sb_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    rd(32'h10, v); chk("arst_status", v, 32'd0);
    push_ops(32'h0000_006D, 4'h1);
    idle(4);
    pop_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
